// File: rtl/proj_lanechk_pkg.sv
// proj_lanechk shared types and helpers.
// Imported by the lane checker and its comparator.
package proj_lanechk_pkg;

  typedef enum logic {
    SEEK = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Width of a counter that must hold 0..n (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/proj_lanechk_if.sv
// proj_lanechk lane interface: W-bit word stream
// with a valid/ready handshake.
interface proj_lanechk_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         vld;
  logic         rdy;

  modport master (output data, vld, input rdy);
  modport slave  (input data, vld, output rdy);
endinterface

// File: rtl/proj_lanechk_cmp.sv
// proj_lanechk comparator: holds the expected word and
// the consecutive-miss count, flags err and unlock.
module proj_lanechk_cmp
  import proj_lanechk_pkg::*;
#(
  parameter int W     = 16,
  parameter int X     = 1,
  parameter int LOSSN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         xfer_i,
  input  logic         lock_i,
  input  logic [W-1:0] data_i,
  output logic         err_o,
  output logic         unlock_o
);

  localparam int MW = cnt_w(LOSSN);

  logic [W-1:0]  exp_q, exp_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          last;

  assign last     = (miss_q == MW'(LOSSN - 1));
  assign err_o    = xfer_i && lock_i && (data_i != exp_q);
  assign unlock_o = err_o && last;

  // Every accepted word re-seeds exp (match or resync).
  always_comb begin
    exp_d  = exp_q;
    miss_d = miss_q;
    if (clr_i) begin
      exp_d  = '0;
      miss_d = '0;
    end else if (xfer_i) begin
      exp_d = data_i + W'(X);
      if (err_o && !last)
        miss_d = miss_q + 1'b1;
      else
        miss_d = '0;
    end
  end

  // Expected word and miss count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q  <= '0;
      miss_q <= '0;
    end else begin
      exp_q  <= exp_d;
      miss_q <= miss_d;
    end
  end

endmodule

// File: rtl/proj_lanechk.sv
// proj_lanechk: lane receive checker. Locks onto the
// stream, counts mismatches and losses of lock.
module proj_lanechk
  import proj_lanechk_pkg::*;
#(
  parameter int W     = 16,
  parameter int X     = 1,
  parameter int EW    = 8,
  parameter int LOSSN = 4,
  parameter int BP    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  proj_lanechk_if.slave lane,
  output logic          locked,
  output logic [EW-1:0] errcntr0,
  output logic [EW-1:0] losscntr,
  output logic          errflg0
);

  state_e        state_q, state_d;
  logic          rdy_q;
  logic [EW-1:0] err_q, err_d;
  logic [EW-1:0] loss_q, loss_d;
  logic [EW-1:0] errcntr0_q;
  logic          errflg0_q;
  logic          xfer, err, unlock;

  // clr discards a coincident transfer.
  assign xfer = lane.vld && rdy_q && !clr;

  proj_lanechk_cmp #(
    .W(W), .X(X), .LOSSN(LOSSN)
  ) u_cmp (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .xfer_i  (xfer),
    .lock_i  (state_q == LOCK),
    .data_i  (lane.data),
    .err_o   (err),
    .unlock_o(unlock)
  );

  // FSM next state and saturating counters.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    loss_d  = loss_q;
    if (clr) begin
      state_d = SEEK;
      err_d   = '0;
      loss_d  = '0;
    end else begin
      if (xfer) begin
        if (state_q == SEEK)
          state_d = LOCK;
        else if (unlock)
          state_d = SEEK;
      end
      if (err && !(&err_q))
        err_d = err_q + 1'b1;
      if (unlock && !(&loss_q))
        loss_d = loss_q + 1'b1;
    end
  end

  // State, counters and registered status copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEEK;
      err_q      <= '0;
      loss_q     <= '0;
      errcntr0_q <= '0;
      errflg0_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      loss_q     <= loss_d;
      errcntr0_q <= err_q;
      errflg0_q  <= (err_q != '0);
    end
  end

  if (BP == 0) begin : g_nobp
    // Ready always high once out of reset.
    always_ff @(posedge clk) begin
      if (rst)
        rdy_q <= 1'b0;
      else
        rdy_q <= 1'b1;
    end
  end else begin : g_bp
    localparam int CW = cnt_w(BP);
    logic [CW-1:0] cnt_q, cnt_d;

    // Mod-(BP+1) throttle count.
    always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(BP))
        cnt_d = '0;
    end

    // Ready high one cycle in every BP+1.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        rdy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        rdy_q <= (cnt_q == '0);
      end
    end
  end

  assign lane.rdy = rdy_q;
  assign locked   = (state_q == LOCK);
  assign errcntr0 = errcntr0_q;
  assign losscntr = loss_q;
  assign errflg0  = errflg0_q;

endmodule

// File: tb/tb_proj_lanechk.sv
// proj_lanechk bench: directed scenarios plus a
// random stream against a word-level model.
module tb_proj_lanechk;

  localparam int AW  = 16;
  localparam int AX  = 1;
  localparam int AEW = 4;
  localparam int ALN = 4;
  localparam int BW  = 8;
  localparam int BX  = 3;
  localparam int BEW = 8;
  localparam int BLN = 2;
  localparam int BBP = 3;

  typedef struct packed {
    int lock;
    int exp;
    int miss;
    int err;
    int loss;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic clr = 1'b0;

  proj_lanechk_if #(.W(AW)) ifa ();
  proj_lanechk_if #(.W(BW)) ifb ();

  logic           a_locked, a_flg;
  logic [AEW-1:0] a_err, a_loss;
  logic           b_locked, b_flg;
  logic [BEW-1:0] b_err, b_loss;

  proj_lanechk #(
    .W(AW), .X(AX), .EW(AEW), .LOSSN(ALN), .BP(0)
  ) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .lane(ifa),
    .locked(a_locked), .errcntr0(a_err),
    .losscntr(a_loss), .errflg0(a_flg)
  );

  proj_lanechk #(
    .W(BW), .X(BX), .EW(BEW), .LOSSN(BLN), .BP(BBP)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .lane(ifb),
    .locked(b_locked), .errcntr0(b_err),
    .losscntr(b_loss), .errflg0(b_flg)
  );

  int   checks   = 0;
  int   failures = 0;
  mdl_t ma;
  int   ea_prev;

  function automatic mdl_t mstep(mdl_t m, int d);
    int mask = (1 << AW) - 1;
    int top  = (1 << AEW) - 1;
    if (m.lock == 0) begin
      m.lock = 1;
      m.exp  = (d + AX) & mask;
      m.miss = 0;
    end else if (d == m.exp) begin
      m.exp  = (m.exp + AX) & mask;
      m.miss = 0;
    end else begin
      m.err  = (m.err < top) ? m.err + 1 : top;
      m.exp  = (d + AX) & mask;
      m.miss = m.miss + 1;
      if (m.miss == ALN) begin
        m.lock = 0;
        m.miss = 0;
        m.loss = (m.loss < top) ? m.loss + 1 : top;
      end
    end
    return m;
  endfunction

  // One cycle on lane A, with the model following along.
  task automatic cyc_a(input logic v, input int d,
                       input logic c);
    logic acc;
    ifa.vld  = v;
    ifa.data = AW'(d);
    clr      = c;
    acc      = v && ifa.rdy;
    ea_prev  = ma.err;
    @(posedge clk);
    #1;
    if (c)
      ma = '0;
    else if (acc)
      ma = mstep(ma, d);
    ifa.vld = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) cyc_a(1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    clr     = 1'b0;
    ifa.vld = 1'b0;
    ifb.vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    ma      = '0;
    ea_prev = 0;
  endtask

  // Offer one word on lane B and wait for it to be taken.
  task automatic send_b(input int d);
    logic acc;
    logic done;
    done     = 1'b0;
    ifb.data = BW'(d);
    ifb.vld  = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      acc = ifb.rdy;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    ifb.vld = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_b_timeout: word %0d not accepted", d);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    ifa.vld  = 1'b0;
    ifb.vld  = 1'b0;
    ifa.data = '0;
    ifb.data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ifa.rdy, a_locked, a_err, a_loss, a_flg} !== '0) begin
      failures++;
      $display("FAIL reset_a: got %h want 0",
               {ifa.rdy, a_locked, a_err, a_loss, a_flg});
    end
    checks++;
    if ({ifb.rdy, b_locked, b_err, b_loss, b_flg} !== '0) begin
      failures++;
      $display("FAIL reset_b: got %h want 0",
               {ifb.rdy, b_locked, b_err, b_loss, b_flg});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({ifa.rdy, ifb.rdy} !== 2'b11) begin
      failures++;
      $display("FAIL rdy_after_reset: got %b want 11",
               {ifa.rdy, ifb.rdy});
    end
  endtask

  task automatic test_lock();
    do_reset();
    cyc_a(1'b1, 5, 1'b0);
    checks++;
    if (a_locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_latency: got %b want 1", a_locked);
    end
    cyc_a(1'b1, 6, 1'b0);
    cyc_a(1'b1, 7, 1'b0);
    cyc_a(1'b1, 8, 1'b0);
    idle_a(2);
    checks++;
    if ({a_locked, a_err, a_flg} !== {1'b1, AEW'(0), 1'b0}) begin
      failures++;
      $display("FAIL lock_state: got lk=%b err=%0d flg=%b want 1 0 0",
               a_locked, a_err, a_flg);
    end
  endtask

  task automatic test_single_error();
    do_reset();
    cyc_a(1'b1, 10, 1'b0);
    cyc_a(1'b1, 11, 1'b0);
    cyc_a(1'b1, 99, 1'b0);
    checks++;
    if (a_err !== AEW'(0)) begin
      failures++;
      $display("FAIL err_early: got %0d want 0", a_err);
    end
    cyc_a(1'b1, 100, 1'b0);
    checks++;
    if ({a_err, a_flg} !== {AEW'(1), 1'b1}) begin
      failures++;
      $display("FAIL err_latency: got err=%0d flg=%b want 1 1",
               a_err, a_flg);
    end
    cyc_a(1'b1, 101, 1'b0);
    idle_a(2);
    checks++;
    if ({a_locked, a_err} !== {1'b1, AEW'(1)}) begin
      failures++;
      $display("FAIL err_resync: got lk=%b err=%0d want 1 1",
               a_locked, a_err);
    end
  endtask

  task automatic test_loss();
    do_reset();
    cyc_a(1'b1, 100, 1'b0);
    cyc_a(1'b1, 1, 1'b0);
    cyc_a(1'b1, 5, 1'b0);
    cyc_a(1'b1, 9, 1'b0);
    checks++;
    if (a_locked !== 1'b1) begin
      failures++;
      $display("FAIL loss_early: got %b want 1", a_locked);
    end
    cyc_a(1'b1, 13, 1'b0);
    checks++;
    if ({a_locked, a_loss} !== {1'b0, AEW'(1)}) begin
      failures++;
      $display("FAIL loss_unlock: got lk=%b loss=%0d want 0 1",
               a_locked, a_loss);
    end
    cyc_a(1'b1, 50, 1'b0);
    idle_a(2);
    checks++;
    if ({a_locked, a_err, a_loss} !== {1'b1, AEW'(4), AEW'(1)}) begin
      failures++;
      $display("FAIL loss_relock: got lk=%b err=%0d loss=%0d want 1 4 1",
               a_locked, a_err, a_loss);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send_b(8'hFA);
    send_b(8'hFD);
    send_b(8'h00);
    send_b(8'h03);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b_locked, b_err, b_loss, b_flg} !==
        {1'b1, BEW'(0), BEW'(0), 1'b0}) begin
      failures++;
      $display("FAIL wrap: got lk=%b err=%0d loss=%0d flg=%b want 1 0 0 0",
               b_locked, b_err, b_loss, b_flg);
    end
  endtask

  task automatic test_backpressure();
    int d;
    int n_acc;
    int n_rdy;
    int last;
    logic acc;
    do_reset();
    d     = 8'h10;
    n_acc = 0;
    n_rdy = 0;
    last  = -1;
    ifb.vld = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ifb.data = BW'(d);
      acc      = ifb.rdy;
      if (acc) begin
        n_rdy++;
        if (last >= 0) begin
          checks++;
          if (i - last != BBP + 1) begin
            failures++;
            $display("FAIL bp_spacing: got %0d want %0d",
                     i - last, BBP + 1);
          end
        end
        last = i;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        d = (d + BX) & 8'hFF;
      end
    end
    ifb.vld = 1'b0;
    checks++;
    if (n_acc != 8) begin
      failures++;
      $display("FAIL bp_count: got %0d want 8", n_acc);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b_locked, b_err} !== {1'b1, BEW'(0)}) begin
      failures++;
      $display("FAIL bp_errors: got lk=%b err=%0d want 1 0",
               b_locked, b_err);
    end
  endtask

  task automatic test_clr();
    do_reset();
    cyc_a(1'b1, 1, 1'b0);
    cyc_a(1'b1, 2, 1'b0);
    cyc_a(1'b1, 50, 1'b0);
    cyc_a(1'b1, 51, 1'b0);
    checks++;
    if (a_err !== AEW'(1)) begin
      failures++;
      $display("FAIL clr_pre: got %0d want 1", a_err);
    end
    cyc_a(1'b1, 99, 1'b1);
    idle_a(2);
    checks++;
    if ({a_locked, a_err, a_flg} !== {1'b0, AEW'(0), 1'b0}) begin
      failures++;
      $display("FAIL clr_state: got lk=%b err=%0d flg=%b want 0 0 0",
               a_locked, a_err, a_flg);
    end
    do_reset();
    cyc_a(1'b1, 1, 1'b0);
    cyc_a(1'b1, 2, 1'b0);
    idle_a(2);
    checks++;
    if ({a_locked, a_err} !== {1'b1, AEW'(0)}) begin
      failures++;
      $display("FAIL rst_relock: got lk=%b err=%0d want 1 0",
               a_locked, a_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    cyc_a(1'b1, 0, 1'b0);
    for (int i = 0; i < 40; i++)
      cyc_a(1'b1, 1000 + 7 * i, 1'b0);
    idle_a(2);
    checks++;
    if ({a_err, a_flg, a_loss, a_locked} !==
        {AEW'(15), 1'b1, AEW'(8), 1'b1}) begin
      failures++;
      $display("FAIL saturate: got err=%0d flg=%b loss=%0d lk=%b want 15 1 8 1",
               a_err, a_flg, a_loss, a_locked);
    end
  endtask

  task automatic test_random();
    logic v;
    logic c;
    int   d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(3) != 0);
      c = ($urandom_range(79) == 0);
      if (ma.lock != 0 && $urandom_range(9) != 0)
        d = ma.exp;
      else
        d = $urandom_range(65535);
      cyc_a(v, d, c);
      checks++;
      if ({a_locked, a_err, a_flg, a_loss} !==
          {ma.lock[0], AEW'(ea_prev), (ea_prev != 0),
           AEW'(ma.loss)}) begin
        failures++;
        $display("FAIL random[%0d]: got lk=%b err=%0d flg=%b loss=%0d want %0d %0d %0d %0d",
                 i, a_locked, a_err, a_flg, a_loss,
                 ma.lock, ea_prev, (ea_prev != 0), ma.loss);
      end
    end
  endtask

  initial begin
    ma      = '0;
    ea_prev = 0;
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_wrap();
    test_backpressure();
    test_clr();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
